// File: rtl/ysyx_23060303_ctrl_seq.sv
// ============================================================================
//  ysyx_23060303_ctrl_seq : multi-cycle PC/IR sequencer with watchdog halt
//  Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060303_ctrl_seq #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          TIMEOUT  = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_resp_valid,
  input  logic [31:0] ifu_resp_inst,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        dec_rd_en,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_ebreak,
  input  logic        dec_illegal,
  input  logic [31:0] exu_next_pc,
  output logic        lsu_req_valid,
  output logic        lsu_req_wen,
  input  logic        lsu_req_ready,
  input  logic        lsu_resp_valid,
  output logic        rf_wen,
  output logic        halt,
  output logic [1:0]  halt_code,
  output logic [63:0] retired,
  output logic [63:0] cycles
);

  localparam int              WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [1:0] HC_EBREAK  = 2'd1;
  localparam logic [1:0] HC_ILLEGAL = 2'd2;
  localparam logic [1:0] HC_FAULT   = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH_REQ  = 3'd0,
    S_FETCH_WAIT = 3'd1,
    S_DECODE     = 3'd2,
    S_EXEC       = 3'd3,
    S_MEM_REQ    = 3'd4,
    S_MEM_WAIT   = 3'd5,
    S_WB         = 3'd6,
    S_HALT       = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       npc_q, npc_d;
  logic [31:0]       inst_q, inst_d;
  logic              halt_q, halt_d;
  logic [1:0]        halt_code_q, halt_code_d;
  logic [63:0]       retired_q, retired_d;
  logic [63:0]       cycles_q, cycles_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic w_wait_state;
  logic w_timeout;

  assign w_wait_state = (state_q == S_FETCH_REQ) || (state_q == S_FETCH_WAIT) ||
                        (state_q == S_MEM_REQ)   || (state_q == S_MEM_WAIT);
  assign w_timeout    = w_wait_state && (wait_q == WAIT_LAST);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    npc_d       = npc_q;
    inst_d      = inst_q;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    retired_d   = retired_q;
    cycles_d    = halt_q ? cycles_q : cycles_q + 64'd1;

    case (state_q)
      S_FETCH_REQ: begin
        if (ifu_req_ready) state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (ifu_resp_valid) begin
          inst_d  = ifu_resp_inst;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_d     = S_HALT;
          halt_d      = 1'b1;
          halt_code_d = HC_ILLEGAL;
        end else if (dec_ebreak) begin
          state_d     = S_HALT;
          halt_d      = 1'b1;
          halt_code_d = HC_EBREAK;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        npc_d = exu_next_pc;
        if (exu_next_pc[1:0] != 2'b00) begin
          state_d     = S_HALT;
          halt_d      = 1'b1;
          halt_code_d = HC_FAULT;
        end else if (dec_is_load || dec_is_store) begin
          state_d = S_MEM_REQ;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM_REQ: begin
        if (lsu_req_ready) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (lsu_resp_valid) state_d = S_WB;
      end
      S_WB: begin
        pc_d      = npc_q;
        retired_d = retired_q + 64'd1;
        state_d   = S_FETCH_REQ;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
    endcase

    // Watchdog only fires if the handshake did not complete this cycle.
    if (w_timeout && (state_d == state_q)) begin
      state_d     = S_HALT;
      halt_d      = 1'b1;
      halt_code_d = HC_FAULT;
    end

    wait_d = ((state_d != state_q) || !w_wait_state) ? '0 : wait_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH_REQ;
      pc_q        <= RESET_PC;
      npc_q       <= RESET_PC;
      inst_q      <= 32'd0;
      halt_q      <= 1'b0;
      halt_code_q <= 2'd0;
      retired_q   <= 64'd0;
      cycles_q    <= 64'd0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      npc_q       <= npc_d;
      inst_q      <= inst_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
      retired_q   <= retired_d;
      cycles_q    <= cycles_d;
      wait_q      <= wait_d;
    end
  end

  // Strobes are Moore outputs of state, held low while reset is applied.
  assign ifu_req_valid = (state_q == S_FETCH_REQ) && !rst;
  assign lsu_req_valid = (state_q == S_MEM_REQ) && !rst;
  assign lsu_req_wen   = (state_q == S_MEM_REQ) && dec_is_store;
  assign rf_wen        = (state_q == S_WB) && dec_rd_en && !dec_is_store && !rst;

  assign ifu_req_addr = pc_q;
  assign pc           = pc_q;
  assign inst         = inst_q;
  assign halt         = halt_q;
  assign halt_code    = halt_code_q;
  assign retired      = retired_q;
  assign cycles       = cycles_q;

endmodule

`default_nettype wire

// File: doc/ysyx_23060303_ctrl_seq.md
# ysyx_23060303_ctrl_seq

Multi-cycle instruction sequencer for the NPC core. It owns the PC and the instruction register and steps each instruction through fetch, decode, execute, optional memory access and write-back. It uses valid/ready handshakes toward the fetch and load/store ports. The instruction register drives the combinational decoder; decoder and EXU results return here to gate register-file write, PC update and halting.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- TIMEOUT, 256, max cycles spent in any wait state before fault halt (≥2)

- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  out  1  fetch request
- ifu_req_ready  in  1  fetch port accepts request
- ifu_req_addr  out  32  fetch address (= pc)
- ifu_resp_valid  in  1  fetch data valid
- ifu_resp_inst  in  32  fetched instruction
- inst  out  32  instruction register, feeds decoder
- pc  out  32  current PC
- dec_rd_en  in  1  instruction writes rd
- dec_is_load / dec_is_store  in  1 each  memory instruction class
- dec_ebreak  in  1  ebreak decoded
- dec_illegal  in  1  no legal decode
- exu_next_pc  in  32  next PC computed by EXU
- lsu_req_valid  out  1  memory request
- lsu_req_wen  out  1  1 = store, 0 = load
- lsu_req_ready  in  1  LSU accepts request
- lsu_resp_valid  in  1  load data / store ack
- rf_wen  out  1  register-file write strobe, one cycle
- halt  out  1  sticky stop
- halt_code  out  2  0 run, 1 ebreak, 2 illegal, 3 fault
- retired  out  64  instructions retired
- cycles  out  64  cycles since reset while not halted

## Operation
- States: FETCH_REQ, FETCH_WAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
- FETCH_REQ: ifu_req_valid=1. If ifu_req_ready, go to FETCH_WAIT.
- FETCH_WAIT: if ifu_resp_valid, set inst←ifu_resp_inst and go to DECODE. A response is only honoured in this state. A response arriving in FETCH_REQ is ignored.
- DECODE: one cycle. Priority order:
  - dec_illegal → HALT with code 2
  - dec_ebreak → HALT with code 1
  - otherwise → EXEC
- EXEC: one cycle. Latch npc←exu_next_pc.
  - If exu_next_pc[1:0]≠0 → HALT with code 3.
  - Else if load or store → MEM_REQ.
  - Else → WB.
- MEM_REQ: lsu_req_valid=1, lsu_req_wen=dec_is_store. If lsu_req_ready, go to MEM_WAIT.
- MEM_WAIT: if lsu_resp_valid, go to WB.
- WB: rf_wen=dec_rd_en & ~dec_is_store. pc←npc, retired+1, then FETCH_REQ.
- HALT: absorbing until rst. All request valids and rf_wen held 0. pc, inst and retired frozen.
- Watchdog:
  - wait counter clears on every state change.
  - It increments each cycle spent in FETCH_REQ, FETCH_WAIT, MEM_REQ or MEM_WAIT.
  - Reaching TIMEOUT → HALT with code 3 on the next edge.
  - A handshake completing in the same cycle as the timeout wins.
- cycles increments every cycle where halt=0. Both 64-bit counters wrap modulo 2^64.
- Request valids are Moore outputs from state. Once asserted, a valid stays high until ready is seen; it is never withdrawn.

## Timing
- Reset values:
  - state=FETCH_REQ, pc=RESET_PC, npc=RESET_PC, inst=0
  - halt=0, halt_code=0, retired=0, cycles=0, wait counter=0
  - all valids and rf_wen = 0
- ifu_req_valid goes to 1 in the first cycle after rst deasserts.
- rst asserted in any state, including mid-handshake or HALT, restores the reset state on the next edge. Outstanding port responses are then dropped.
- Best-case latency with ready and resp in the earliest cycle:
  - ALU/branch instruction: 5 cycles (FQ, FW, D, E, WB)
  - load/store: 7 cycles
- rf_wen and the retired increment occur in the WB cycle. The new pc is visible the cycle after WB.
- halt and halt_code are registered. Both are visible the cycle after the deciding state.
- Decoder inputs are sampled only in DECODE, EXEC, MEM_REQ and WB. Between fetches they are stable because inst is stable.

## Test plan
- **Reset then addi:** rst high 2 cycles, ready/resp immediate, inst 0x00100093 (rd_en=1) → ifu_req_addr=0x8000_0000. rf_wen pulses in cycle 5. pc becomes 0x8000_0004 and retired=1.
- **Load with stalls:** lsu_req_ready delayed 3 cycles, lsu_resp delayed 2 cycles → lsu_req_valid held 4 cycles, lsu_req_wen=0. rf_wen arrives 12 cycles after fetch start.
- **Store:** dec_is_store=1, dec_rd_en=1 → lsu_req_wen=1 and rf_wen stays 0 in WB. retired increments.
- **Ebreak/illegal:** dec_ebreak → halt=1, code 1, no rf_wen, pc unchanged. A separate run with dec_illegal and dec_ebreak both set → code 2.
- **Misaligned target:** exu_next_pc=0x8000_0002 → halt_code 3 after EXEC, and no further ifu_req_valid.
- **Timeout and reset recovery:** ifu_req_ready tied 0 with TIMEOUT=8 → halt code 3 after 8 cycles with cycles frozen. Pulse rst mid-MEM_WAIT in another run → pc=RESET_PC and counters=0 on the next cycle.
